// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between multi-cycle FSM and datapath
interface multicycle_control_if;
   logic       start_i;
   logic [5:0] Op_i;
   logic       PCWrite_o;
   logic       PCWriteCond_o;
   logic       IorD_o;
   logic       MemRead_o;
   logic       MemWrite_o;
   logic       IRWrite_o;
   logic       MemtoReg_o;
   logic       RegWrite_o;
   logic       RegDst_o;
   logic       ALUSrcA_o;
   logic [1:0] ALUSrcB_o;
   logic [1:0] ALUOp_o;
   logic [1:0] PCSource_o;
   logic       illegal_o;
   logic [3:0] state_o;

   // Controller side: consumes start/opcode, drives every datapath control
   modport master (
      input  start_i, Op_i,
      output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
             MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
             PCSource_o, illegal_o, state_o
   );

   // Datapath side: supplies start/opcode, observes the controls
   modport slave (
      output start_i, Op_i,
      input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
             MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
             PCSource_o, illegal_o, state_o
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multi-cycle MIPS datapath
module multicycle_control #(
   parameter int         MEM_LAT  = 1,
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ADDIEX = 4'd11,
      S_ADDIWB = 4'd12
   } state_t;

   localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

   state_t     state;
   logic [3:0] wait_cnt;
   logic [5:0] op_q;
   logic       last_wait;
   logic       op_known;

   assign last_wait = (wait_cnt == LAST_WAIT);

   // Opcode recognition for the DECODE-cycle illegal flag
   always_comb begin
      op_known = 1'b0;
      case (bus.Op_i)
         OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_known = 1'b1;
         default:                                       op_known = 1'b0;
      endcase
   end

   // State sequencing; wait counter runs only while staying in a memory state and is zero on every entry
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         op_q     <= 6'd0;
      end else begin
         wait_cnt <= 4'd0;
         case (state)
            S_IDLE:   if (bus.start_i) state <= S_FETCH;
            S_FETCH:  if (last_wait) state <= S_DECODE;
                      else wait_cnt <= wait_cnt + 4'd1;
            S_DECODE: begin
               op_q <= bus.Op_i;
               case (bus.Op_i)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_EXEC;
                  OP_BEQ:       state <= S_BRANCH;
                  OP_J:         state <= S_JUMP;
                  OP_ADDI:      state <= S_ADDIEX;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEMADR: state <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (last_wait) state <= S_MEMWB;
                      else wait_cnt <= wait_cnt + 4'd1;
            S_MEMWR:  if (last_wait) state <= S_FETCH;
                      else wait_cnt <= wait_cnt + 4'd1;
            S_EXEC:   state <= S_RWB;
            S_ADDIEX: state <= S_ADDIWB;
            default:  state <= S_FETCH;
         endcase
      end
   end

   // Datapath controls decoded from the current state (and wait counter in FETCH)
   always_comb begin
      bus.PCWrite_o     = 1'b0;
      bus.PCWriteCond_o = 1'b0;
      bus.IorD_o        = 1'b0;
      bus.MemRead_o     = 1'b0;
      bus.MemWrite_o    = 1'b0;
      bus.IRWrite_o     = 1'b0;
      bus.MemtoReg_o    = 1'b0;
      bus.RegWrite_o    = 1'b0;
      bus.RegDst_o      = 1'b0;
      bus.ALUSrcA_o     = 1'b0;
      bus.ALUSrcB_o     = 2'b00;
      bus.ALUOp_o       = 2'b00;
      bus.PCSource_o    = 2'b00;
      bus.illegal_o     = 1'b0;
      case (state)
         S_FETCH: begin
            bus.MemRead_o = 1'b1;
            bus.ALUSrcB_o = 2'b01;
            bus.IRWrite_o = last_wait;
            bus.PCWrite_o = last_wait;
         end
         S_DECODE: begin
            bus.ALUSrcB_o = 2'b11;
            bus.illegal_o = ~op_known;
         end
         S_MEMADR: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUSrcB_o = 2'b10;
         end
         S_MEMRD: begin
            bus.MemRead_o = 1'b1;
            bus.IorD_o    = 1'b1;
         end
         S_MEMWB: begin
            bus.RegWrite_o = 1'b1;
            bus.MemtoReg_o = 1'b1;
         end
         S_MEMWR: begin
            bus.MemWrite_o = 1'b1;
            bus.IorD_o     = 1'b1;
         end
         S_EXEC: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUOp_o   = 2'b10;
         end
         S_RWB: begin
            bus.RegWrite_o = 1'b1;
            bus.RegDst_o   = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA_o     = 1'b1;
            bus.ALUOp_o       = 2'b01;
            bus.PCWriteCond_o = 1'b1;
            bus.PCSource_o    = 2'b01;
         end
         S_JUMP: begin
            bus.PCWrite_o  = 1'b1;
            bus.PCSource_o = 2'b10;
         end
         S_ADDIEX: begin
            bus.ALUSrcA_o = 1'b1;
            bus.ALUSrcB_o = 2'b10;
         end
         S_ADDIWB: bus.RegWrite_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control
module tb_multicycle_control;

   // Control vector bit order:
   // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegWrite RegDst ALUSrcA | ALUSrcB | ALUOp | PCSource | illegal
   localparam logic [16:0] C_ZERO   = 17'b0000000000_00_00_00_0;
   localparam logic [16:0] C_FETCHL = 17'b1001010000_01_00_00_0;
   localparam logic [16:0] C_FETCHW = 17'b0001000000_01_00_00_0;
   localparam logic [16:0] C_DEC    = 17'b0000000000_11_00_00_0;
   localparam logic [16:0] C_DECILL = 17'b0000000000_11_00_00_1;
   localparam logic [16:0] C_MEMADR = 17'b0000000001_10_00_00_0;
   localparam logic [16:0] C_MEMRD  = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] C_MEMWB  = 17'b0000001100_00_00_00_0;
   localparam logic [16:0] C_MEMWR  = 17'b0010100000_00_00_00_0;
   localparam logic [16:0] C_EXEC   = 17'b0000000001_00_10_00_0;
   localparam logic [16:0] C_RWB    = 17'b0000000110_00_00_00_0;
   localparam logic [16:0] C_BRANCH = 17'b0100000001_00_01_01_0;
   localparam logic [16:0] C_JUMP   = 17'b1000000000_00_00_10_0;
   localparam logic [16:0] C_ADDIEX = 17'b0000000001_10_00_00_0;
   localparam logic [16:0] C_ADDIWB = 17'b0000000100_00_00_00_0;

   typedef struct {
      logic [5:0]  op;
      logic [3:0]  st;
      logic [16:0] ctl;
   } vec_t;

   logic clk;
   logic rst1;
   logic rst3;
   int   checks;
   int   failures;

   multicycle_control_if if1 ();
   multicycle_control_if if3 ();

   multicycle_control #(.MEM_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(if1));
   multicycle_control #(.MEM_LAT(3)) dut3 (.clk_i(clk), .rst_i(rst3), .bus(if3));

   logic [16:0] ctl1;
   logic [16:0] ctl3;
   assign ctl1 = {if1.PCWrite_o, if1.PCWriteCond_o, if1.IorD_o, if1.MemRead_o, if1.MemWrite_o,
                  if1.IRWrite_o, if1.MemtoReg_o, if1.RegWrite_o, if1.RegDst_o, if1.ALUSrcA_o,
                  if1.ALUSrcB_o, if1.ALUOp_o, if1.PCSource_o, if1.illegal_o};
   assign ctl3 = {if3.PCWrite_o, if3.PCWriteCond_o, if3.IorD_o, if3.MemRead_o, if3.MemWrite_o,
                  if3.IRWrite_o, if3.MemtoReg_o, if3.RegWrite_o, if3.RegDst_o, if3.ALUSrcA_o,
                  if3.ALUSrcB_o, if3.ALUOp_o, if3.PCSource_o, if3.illegal_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [5:0] op, input logic [3:0] st, input logic [16:0] ctl);
      vec_t v;
      v.op  = op;
      v.st  = st;
      v.ctl = ctl;
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] ast, input logic [16:0] actl,
                        input logic [3:0] est, input logic [16:0] ectl);
      checks++;
      if (ast !== est) begin
         failures++;
         $display("FAIL %s state got=%0d exp=%0d", name, ast, est);
      end
      checks++;
      if (actl !== ectl) begin
         failures++;
         $display("FAIL %s ctl got=%b exp=%b", name, actl, ectl);
      end
   endtask

   // One clock of a table row: drive opcode, compare at negedge, advance past next posedge
   task automatic step(input int which, input vec_t v, input string name);
      if (which == 1) if1.Op_i = v.op;
      else            if3.Op_i = v.op;
      @(negedge clk);
      if (which == 1) check(name, if1.state_o, ctl1, v.st, v.ctl);
      else            check(name, if3.state_o, ctl3, v.st, v.ctl);
      @(posedge clk);
      #1;
   endtask

   vec_t v1[$];
   vec_t v3[$];

   initial begin
      checks   = 0;
      failures = 0;

      // MEM_LAT=1 stream: R, addi, lw, sw, beq, j, illegal, R with Op change in EXEC
      v1.push_back(mk(6'h00, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h00, 4'd2,  C_DEC));
      v1.push_back(mk(6'h00, 4'd7,  C_EXEC));
      v1.push_back(mk(6'h00, 4'd8,  C_RWB));
      v1.push_back(mk(6'h08, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h08, 4'd2,  C_DEC));
      v1.push_back(mk(6'h08, 4'd11, C_ADDIEX));
      v1.push_back(mk(6'h08, 4'd12, C_ADDIWB));
      v1.push_back(mk(6'h23, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h23, 4'd2,  C_DEC));
      v1.push_back(mk(6'h23, 4'd3,  C_MEMADR));
      v1.push_back(mk(6'h23, 4'd4,  C_MEMRD));
      v1.push_back(mk(6'h23, 4'd5,  C_MEMWB));
      v1.push_back(mk(6'h2B, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h2B, 4'd2,  C_DEC));
      v1.push_back(mk(6'h2B, 4'd3,  C_MEMADR));
      v1.push_back(mk(6'h2B, 4'd6,  C_MEMWR));
      v1.push_back(mk(6'h04, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h04, 4'd2,  C_DEC));
      v1.push_back(mk(6'h04, 4'd9,  C_BRANCH));
      v1.push_back(mk(6'h02, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h02, 4'd2,  C_DEC));
      v1.push_back(mk(6'h02, 4'd10, C_JUMP));
      v1.push_back(mk(6'h3F, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h3F, 4'd2,  C_DECILL));
      v1.push_back(mk(6'h00, 4'd1,  C_FETCHL));
      v1.push_back(mk(6'h00, 4'd2,  C_DEC));
      v1.push_back(mk(6'h23, 4'd7,  C_EXEC));
      v1.push_back(mk(6'h23, 4'd8,  C_RWB));
      v1.push_back(mk(6'h00, 4'd1,  C_FETCHL));

      // MEM_LAT=3: full lw (9 cycles), then sw up to its first MEMWR cycle
      v3.push_back(mk(6'h23, 4'd1, C_FETCHW));
      v3.push_back(mk(6'h23, 4'd1, C_FETCHW));
      v3.push_back(mk(6'h23, 4'd1, C_FETCHL));
      v3.push_back(mk(6'h23, 4'd2, C_DEC));
      v3.push_back(mk(6'h23, 4'd3, C_MEMADR));
      v3.push_back(mk(6'h23, 4'd4, C_MEMRD));
      v3.push_back(mk(6'h23, 4'd4, C_MEMRD));
      v3.push_back(mk(6'h23, 4'd4, C_MEMRD));
      v3.push_back(mk(6'h23, 4'd5, C_MEMWB));
      v3.push_back(mk(6'h2B, 4'd1, C_FETCHW));
      v3.push_back(mk(6'h2B, 4'd1, C_FETCHW));
      v3.push_back(mk(6'h2B, 4'd1, C_FETCHL));
      v3.push_back(mk(6'h2B, 4'd2, C_DEC));
      v3.push_back(mk(6'h2B, 4'd3, C_MEMADR));
      v3.push_back(mk(6'h2B, 4'd6, C_MEMWR));

      rst1 = 1'b1;
      rst3 = 1'b1;
      if1.start_i = 1'b0;
      if1.Op_i    = 6'h00;
      if3.start_i = 1'b0;
      if3.Op_i    = 6'h00;
      #1;
      check("reset1", if1.state_o, ctl1, 4'd0, C_ZERO);
      check("reset3", if3.state_o, ctl3, 4'd0, C_ZERO);

      repeat (2) @(posedge clk);
      #1;
      rst1 = 1'b0;

      // Idle without start for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("idle1_%0d", i), if1.state_o, ctl1, 4'd0, C_ZERO);
         @(posedge clk);
         #1;
      end

      // One-cycle start pulse then the MEM_LAT=1 stream
      if1.start_i = 1'b1;
      @(posedge clk);
      #1;
      if1.start_i = 1'b0;
      for (int i = 0; i < v1.size(); i++) step(1, v1[i], $sformatf("l1_row%0d", i));

      // MEM_LAT=3 instance
      rst3 = 1'b0;
      @(negedge clk);
      check("idle3", if3.state_o, ctl3, 4'd0, C_ZERO);
      @(posedge clk);
      #1;
      if3.start_i = 1'b1;
      @(posedge clk);
      #1;
      if3.start_i = 1'b0;
      for (int i = 0; i < v3.size(); i++) step(3, v3[i], $sformatf("l3_row%0d", i));

      // Now in the 2nd MEMWR cycle: reset must clear outputs without a clock
      check("memwr2", if3.state_o, ctl3, 4'd6, C_MEMWR);
      rst3 = 1'b1;
      #1;
      check("rst_async", if3.state_o, ctl3, 4'd0, C_ZERO);
      @(negedge clk);
      check("rst_hold", if3.state_o, ctl3, 4'd0, C_ZERO);
      @(posedge clk);
      #1;
      rst3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_idle%0d", i), if3.state_o, ctl3, 4'd0, C_ZERO);
         @(posedge clk);
         #1;
      end

      // Restart: wait counter must begin again from zero
      if3.start_i = 1'b1;
      @(posedge clk);
      #1;
      if3.start_i = 1'b0;
      step(3, mk(6'h08, 4'd1, C_FETCHW), "restart_f0");
      step(3, mk(6'h08, 4'd1, C_FETCHW), "restart_f1");
      step(3, mk(6'h08, 4'd1, C_FETCHL), "restart_f2");
      step(3, mk(6'h08, 4'd2, C_DEC),    "restart_dec");
      step(3, mk(6'h08, 4'd11, C_ADDIEX), "restart_addiex");
      step(3, mk(6'h08, 4'd12, C_ADDIWB), "restart_addiwb");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
